// File: rtl/mem_sized_ctrl_if.sv
// mem_sized_ctrl_if: request/response bundle for the byte/half/word sized memory controller.
interface mem_sized_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              clr;
    logic              busy;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic [1:0]        wsize;
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic [1:0]        rsize;
    logic              rsigned;
    logic [31:0]       rdata;
    logic              rvalid;
    logic              err;

    modport master (
        output clr, wen, waddr, wdata, wsize, ren, raddr, rsize, rsigned,
        input  busy, rdata, rvalid, err
    );
    modport slave (
        input  clr, wen, waddr, wdata, wsize, ren, raddr, rsize, rsigned,
        output busy, rdata, rvalid, err
    );
endinterface

// File: rtl/mem_sized_ctrl.sv
// mem_sized_ctrl: 32-bit word memory with sized, sign-extending accesses and a clear sweep.
module mem_sized_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    mem_sized_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     cnt;
    logic [31:0]       mem [DEPTH];
    logic              busy, wok, rok, wr_go, rd_go, err_q;
    logic [3:0]        be;
    logic [31:0]       wd, rword, sh, ext;
    logic [RD_LAT-1:0] pv;
    logic [31:0]       pd [RD_LAT];

    function automatic logic legal(input logic [ADDR_W-1:0] a, input logic [1:0] s);
        return s != 2'b11 && !(s == 2'b01 && a[0]) && !(s == 2'b10 && a[1:0] != 2'b00) &&
               ({1'b0, a[ADDR_W-1:2]} < (ADDR_W-1)'(DEPTH));
    endfunction

    assign busy  = state == CLEAR;
    assign wok   = legal(bus.waddr, bus.wsize);
    assign rok   = legal(bus.raddr, bus.rsize);
    assign wr_go = rst && !busy && bus.wen && wok;
    assign rd_go = rst && !busy && bus.ren && rok;

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (bus.clr ? CLEAR : IDLE)
                                   : ((cnt == AW'(DEPTH - 1)) ? IDLE : CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= busy ? cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        be    = (bus.wsize == 2'b00) ? 4'b0001 << bus.waddr[1:0]
              : (bus.wsize == 2'b01) ? 4'b0011 << bus.waddr[1:0] : 4'b1111;
        wd    = bus.wdata << {bus.waddr[1:0], 3'b000};
        rword = mem[bus.raddr[AW+1:2]];
        sh    = rword >> {bus.raddr[1:0], 3'b000};
        ext   = (bus.rsize == 2'b00) ? {{24{bus.rsigned & sh[7]}}, sh[7:0]}
              : (bus.rsize == 2'b01) ? {{16{bus.rsigned & sh[15]}}, sh[15:0]} : sh;
    end

    // Array has no reset; nonblocking update makes a same-cycle read see the old word.
    always_ff @(posedge clk) begin
        if (rst && busy)
            mem[cnt] <= '0;
        else if (wr_go)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[bus.waddr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pv    <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
        end else begin
            pv[0] <= rd_go;
            if (rd_go) pd[0] <= ext;
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) pd[i] <= pd[i-1];
            end
            err_q <= busy ? (bus.wen || bus.ren)
                          : ((bus.wen && !wok) || (bus.ren && !rok));
        end
    end

    assign bus.busy   = busy;
    assign bus.rvalid = pv[RD_LAT-1];
    assign bus.rdata  = pd[RD_LAT-1];
    assign bus.err    = err_q;
endmodule

// File: tb/tb_mem_sized_ctrl.sv
// tb_mem_sized_ctrl: directed checks of sized access, rejection, read-first and clear sweep.
module tb_mem_sized_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n, bad;

    always #5 clk = ~clk;

    mem_sized_ctrl_if #(.ADDR_W(16)) bus ();

    mem_sized_ctrl #(.ADDR_W(16), .DEPTH(256), .RD_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        bus.wen = 1'b1; bus.waddr = a; bus.wdata = d; bus.wsize = s;
        @(negedge clk);
        bus.wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [1:0] s, input logic sg);
        @(negedge clk);
        bus.ren = 1'b1; bus.raddr = a; bus.rsize = s; bus.rsigned = sg;
        @(negedge clk);
        bus.ren = 1'b0;
    endtask

    initial begin
        bus.clr = 0; bus.wen = 0; bus.waddr = 0; bus.wdata = 0; bus.wsize = 0;
        bus.ren = 0; bus.raddr = 0; bus.rsize = 0; bus.rsigned = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rdata", bus.rdata, 0);
        rst = 1'b1;

        wr(16'h0010, 32'h8000_00F1, 2'b10);
        chk("wword_err", bus.err, 0);
        rd(16'h0010, 2'b00, 1'b1);
        chk("rbyte_s_valid", bus.rvalid, 1);
        chk("rbyte_s", bus.rdata, 32'hFFFF_FFF1);
        rd(16'h0010, 2'b00, 1'b0);
        chk("rbyte_u", bus.rdata, 32'h0000_00F1);
        @(negedge clk);
        chk("hold_rvalid", bus.rvalid, 0);
        chk("hold_rdata", bus.rdata, 32'h0000_00F1);

        wr(16'h0010, 32'h1122_3344, 2'b10);
        wr(16'h0012, 32'h0000_BEEF, 2'b01);
        rd(16'h0010, 2'b10, 1'b0);
        chk("half_merge", bus.rdata, 32'hBEEF_3344);
        rd(16'h0013, 2'b00, 1'b1);
        chk("byte3_s", bus.rdata, 32'hFFFF_FFBE);
        rd(16'h0012, 2'b01, 1'b1);
        chk("half_s", bus.rdata, 32'hFFFF_BEEF);
        rd(16'h0012, 2'b01, 1'b0);
        chk("half_u", bus.rdata, 32'h0000_BEEF);
        rd(16'h0011, 2'b00, 1'b1);
        chk("byte1", bus.rdata, 32'h0000_0033);

        wr(16'h0011, 32'h0000_1234, 2'b01);
        chk("misal_w_err", bus.err, 1);
        @(negedge clk);
        chk("misal_w_err_pulse", bus.err, 0);
        wr(16'h0010, 32'hDEAD_DEAD, 2'b11);
        chk("size3_w_err", bus.err, 1);
        rd(16'h0010, 2'b10, 1'b0);
        chk("misal_unchanged", bus.rdata, 32'hBEEF_3344);
        rd(16'h0400, 2'b10, 1'b0);
        chk("oor_r_err", bus.err, 1);
        chk("oor_r_rvalid", bus.rvalid, 0);
        rd(16'h0012, 2'b10, 1'b0);
        chk("misal_r_err", bus.err, 1);
        chk("misal_r_rvalid", bus.rvalid, 0);

        @(negedge clk);
        bus.wen = 1; bus.waddr = 16'h0401; bus.wsize = 2'b01;
        bus.ren = 1; bus.raddr = 16'h0003; bus.rsize = 2'b10;
        @(negedge clk);
        bus.wen = 0; bus.ren = 0;
        chk("dual_rej_err", bus.err, 1);
        @(negedge clk);
        chk("dual_rej_pulse", bus.err, 0);

        wr(16'h0020, 32'h0000_0005, 2'b10);
        @(negedge clk);
        bus.wen = 1; bus.waddr = 16'h0020; bus.wdata = 32'h0000_0009; bus.wsize = 2'b10;
        bus.ren = 1; bus.raddr = 16'h0020; bus.rsize = 2'b10; bus.rsigned = 0;
        @(negedge clk);
        bus.wen = 0; bus.ren = 0;
        chk("rdfirst_old", bus.rdata, 32'h0000_0005);
        rd(16'h0020, 2'b10, 1'b0);
        chk("rdfirst_new", bus.rdata, 32'h0000_0009);

        @(negedge clk);
        bus.ren = 1; bus.raddr = 16'h0010; bus.rsize = 2'b10;
        @(negedge clk);
        bus.raddr = 16'h0020;
        chk("b2b_v0", bus.rvalid, 1);
        chk("b2b_d0", bus.rdata, 32'hBEEF_3344);
        @(negedge clk);
        bus.ren = 0;
        chk("b2b_v1", bus.rvalid, 1);
        chk("b2b_d1", bus.rdata, 32'h0000_0009);

        @(negedge clk);
        bus.clr = 1;
        @(negedge clk);
        bus.clr = 0;
        chk("clr_busy_rise", bus.busy, 1);
        n = 0;
        for (int i = 0; i < 400 && bus.busy; i++) begin
            n++;
            if (n == 10) begin
                bus.ren = 1; bus.raddr = 16'h0010; bus.rsize = 2'b10;
            end
            if (n == 11) begin
                bus.ren = 0;
                chk("busy_ren_err", bus.err, 1);
                chk("busy_ren_rvalid", bus.rvalid, 0);
            end
            @(negedge clk);
        end
        chk("clr_busy_cycles", n, 256);
        bad = 0;
        for (int w = 0; w < 256; w++) begin
            rd(16'(w * 4), 2'b10, 1'b0);
            if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) bad++;
        end
        chk("clr_all_zero", bad, 0);

        wr(16'h0320, 32'h1234_5678, 2'b10);
        wr(16'h018C, 32'h0000_AAAA, 2'b10);
        rd(16'h018C, 2'b10, 1'b0);
        chk("pre_w99", bus.rdata, 32'h0000_AAAA);
        @(negedge clk);
        bus.clr = 1;
        @(negedge clk);
        bus.clr = 0;
        n = 0;
        for (int i = 0; i < 400 && bus.busy; i++) begin
            n++;
            if (n == 101) rst = 1'b0;
            @(negedge clk);
        end
        chk("abort_at", n, 101);
        chk("abort_busy", bus.busy, 0);
        chk("abort_rdata", bus.rdata, 0);
        chk("abort_rvalid", bus.rvalid, 0);
        rst = 1'b1;
        rd(16'h018C, 2'b10, 1'b0);
        chk("abort_w99", bus.rdata, 32'h0);
        rd(16'h0000, 2'b10, 1'b0);
        chk("abort_w0", bus.rdata, 32'h0);
        rd(16'h0320, 2'b10, 1'b0);
        chk("abort_w200", bus.rdata, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
